ds_decode_pipe: RTL and testbench

DS_DECODE_PIPE -- requirements
Module: ds_decode_pipe

---
 rtl/ds_decode_pipe.sv | 194 +++++++++++++++++++
 tb/tb_ds_decode_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ds_decode_pipe.sv
// ds_decode_pipe
// Decodes DS-form doubleword load/store instructions (primary opcodes 58 and
// 62) into micro-ops. There is a single registered output stage with a
// valid/ready handshake. Store Quadword can optionally be cracked into two
// doubleword stores that are emitted on consecutive handshakes.
//
// Ports
//   clock_i, reset_i        clock; synchronous active-high reset
//   enable_i, instruction_i incoming instruction (big-endian bit numbering)
//   stall_o                 instruction not accepted this cycle
//   ready_i                 downstream accepts the current micro-op
//   enable_o                micro-op valid
//   reg1_o, reg2_o          RT/RS and RA
//   reg2ValOrZero_o         RA==0 reads as literal zero
//   imm_o                   sign-extended displacement (+8 for the 2nd STQ half)
//   opSel_o                 0 LD, 1 LDU, 2 LWA, 3 STD, 4 STDU, 5 STQ
//   uopIdx_o, lastUop_o     micro-op index, last micro-op of instruction
//   illegal_o               invalid encoding (routed to the trap unit)
//   functionalUnitCode_o    dispatch target
module ds_decode_pipe #(
    parameter int opcodeWidth      = 6,
    parameter int regWidth         = 5,
    parameter int immWidth         = 14,
    parameter int instructionWidth = 32,
    parameter int dataWidth        = 64,
    parameter int unitCodeWidth    = 3,
    parameter int LdStUnitCode     = 2,
    parameter int TrapUnitCode     = 4,
    parameter bit CRACK_STQ        = 1'b1
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        enable_i,
    input  logic [instructionWidth-1:0] instruction_i,
    output logic                        stall_o,
    input  logic                        ready_i,
    output logic                        enable_o,
    output logic [regWidth-1:0]         reg1_o,
    output logic [regWidth-1:0]         reg2_o,
    output logic                        reg2ValOrZero_o,
    output logic [dataWidth-1:0]        imm_o,
    output logic [2:0]                  opSel_o,
    output logic                        uopIdx_o,
    output logic                        lastUop_o,
    output logic                        illegal_o,
    output logic [unitCodeWidth-1:0]    functionalUnitCode_o
);

    localparam logic [2:0] OP_LD   = 3'd0;
    localparam logic [2:0] OP_LDU  = 3'd1;
    localparam logic [2:0] OP_LWA  = 3'd2;
    localparam logic [2:0] OP_STD  = 3'd3;
    localparam logic [2:0] OP_STDU = 3'd4;
    localparam logic [2:0] OP_STQ  = 3'd5;

    // Field positions, counted down from the MSB (instruction bit 0).
    localparam int RT_HI = instructionWidth - 1 - opcodeWidth;
    localparam int RA_HI = RT_HI - regWidth;
    localparam int DS_HI = RA_HI - regWidth;

    typedef struct packed {
        logic [regWidth-1:0]      reg1;
        logic [regWidth-1:0]      reg2;
        logic                     reg2_zero;
        logic [dataWidth-1:0]     imm;
        logic [2:0]               op_sel;
        logic                     uop_idx;
        logic                     last_uop;
        logic                     illegal;
        logic [unitCodeWidth-1:0] unit;
    } uop_t;

    typedef enum logic {IDLE, CRACK} state_t;

    state_t state_q, state_d;
    uop_t   out_q, dec;
    logic   enable_q;

    logic [opcodeWidth-1:0] opc;
    logic [regWidth-1:0]    rt, ra;
    logic [immWidth-1:0]    ds;
    logic [1:0]             xo;
    logic [2:0]             sel;
    logic                   bad, stq_crack;
    logic                   consumed, accept, load_new, load_uop1;

    assign opc = instruction_i[instructionWidth-1 -: opcodeWidth];
    assign rt  = instruction_i[RT_HI -: regWidth];
    assign ra  = instruction_i[RA_HI -: regWidth];
    assign ds  = instruction_i[DS_HI -: immWidth];
    assign xo  = instruction_i[1:0];

    // Opcode/XO decode plus the register-field legality rules.
    always_comb begin
        sel = OP_LD;
        bad = 1'b0;
        if (opc == opcodeWidth'(58)) begin
            case (xo)
                2'd0:    sel = OP_LD;
                2'd1:    sel = OP_LDU;
                2'd2:    sel = OP_LWA;
                default: bad = 1'b1;
            endcase
        end else if (opc == opcodeWidth'(62)) begin
            case (xo)
                2'd0:    sel = OP_STD;
                2'd1:    sel = OP_STDU;
                2'd2:    sel = OP_STQ;
                default: bad = 1'b1;
            endcase
        end else begin
            bad = 1'b1;
        end
        // Update forms need a real base register; LDU cannot target its base.
        if ((sel == OP_LDU || sel == OP_STDU) && ra == '0) bad = 1'b1;
        if (sel == OP_LDU && ra == rt)                      bad = 1'b1;
        // STQ writes an even/odd register pair.
        if (sel == OP_STQ && rt[0])                         bad = 1'b1;
    end

    assign stq_crack = CRACK_STQ && !bad && sel == OP_STQ;

    always_comb begin
        dec           = '0;
        dec.reg1      = rt;
        dec.reg2      = ra;
        dec.reg2_zero = (sel == OP_LD) || (sel == OP_LWA) || (sel == OP_STD) || (sel == OP_STQ);
        dec.imm       = {{(dataWidth-immWidth-2){ds[immWidth-1]}}, ds, 2'b00};
        dec.op_sel    = bad ? OP_LD : (stq_crack ? OP_STD : sel);
        dec.uop_idx   = 1'b0;
        dec.last_uop  = !stq_crack;
        dec.illegal   = bad;
        dec.unit      = bad ? unitCodeWidth'(TrapUnitCode) : unitCodeWidth'(LdStUnitCode);
    end

    // Handshake and crack sequencing.
    always_comb begin
        state_d   = state_q;
        load_new  = 1'b0;
        load_uop1 = 1'b0;
        consumed  = enable_q && ready_i;
        stall_o   = (state_q == CRACK) || (enable_q && !ready_i);
        accept    = enable_i && !stall_o;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    load_new = 1'b1;
                    if (stq_crack) state_d = CRACK;
                end
            end
            CRACK: begin
                if (consumed) begin
                    load_uop1 = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            enable_q <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q <= state_d;
            if (load_uop1) begin
                // Second half of STQ: next register of the pair, next doubleword.
                out_q.reg1     <= out_q.reg1 + regWidth'(1);
                out_q.imm      <= out_q.imm + dataWidth'(8);
                out_q.uop_idx  <= 1'b1;
                out_q.last_uop <= 1'b1;
            end else if (load_new) begin
                out_q    <= dec;
                enable_q <= 1'b1;
            end else if (consumed) begin
                enable_q <= 1'b0;
            end
        end
    end

    assign enable_o             = enable_q;
    assign reg1_o               = out_q.reg1;
    assign reg2_o               = out_q.reg2;
    assign reg2ValOrZero_o      = out_q.reg2_zero;
    assign imm_o                = out_q.imm;
    assign opSel_o              = out_q.op_sel;
    assign uopIdx_o             = out_q.uop_idx;
    assign lastUop_o            = out_q.last_uop;
    assign illegal_o            = out_q.illegal;
    assign functionalUnitCode_o = out_q.unit;

endmodule

// File: tb/tb_ds_decode_pipe.sv
// Testbench for ds_decode_pipe: two instances (STQ cracked / not cracked) fed
// the same stimulus, each compared every cycle against a queue-of-micro-ops
// reference model derived from the decode rules.
module tb_ds_decode_pipe;

    typedef struct packed {
        logic        ill;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        rz;
        logic [63:0] imm;
        logic [2:0]  op;
        logic        idx;
        logic        last;
        logic [2:0]  unit;
    } uop_t;

    logic        clk = 1'b0;
    logic        rst, en_i, rdy;
    logic [31:0] ins;

    logic        stall [2];
    logic        en_o  [2];
    logic [4:0]  r1    [2];
    logic [4:0]  r2    [2];
    logic        rz    [2];
    logic [63:0] imm   [2];
    logic [2:0]  op    [2];
    logic        idx   [2];
    logic        last  [2];
    logic        ill   [2];
    logic [2:0]  unit  [2];

    int   ncmp = 0, nerr = 0;
    uop_t mq [2][2];
    int   mn [2];
    bit   fresh [2];
    bit   st_exp [2];
    bit   armed = 0;

    always #5 clk = ~clk;

    ds_decode_pipe #(.CRACK_STQ(1'b1)) u_crack (
        .clock_i(clk), .reset_i(rst), .enable_i(en_i), .instruction_i(ins),
        .stall_o(stall[0]), .ready_i(rdy), .enable_o(en_o[0]),
        .reg1_o(r1[0]), .reg2_o(r2[0]), .reg2ValOrZero_o(rz[0]), .imm_o(imm[0]),
        .opSel_o(op[0]), .uopIdx_o(idx[0]), .lastUop_o(last[0]),
        .illegal_o(ill[0]), .functionalUnitCode_o(unit[0])
    );

    ds_decode_pipe #(.CRACK_STQ(1'b0)) u_nocrack (
        .clock_i(clk), .reset_i(rst), .enable_i(en_i), .instruction_i(ins),
        .stall_o(stall[1]), .ready_i(rdy), .enable_o(en_o[1]),
        .reg1_o(r1[1]), .reg2_o(r2[1]), .reg2ValOrZero_o(rz[1]), .imm_o(imm[1]),
        .opSel_o(op[1]), .uopIdx_o(idx[1]), .lastUop_o(last[1]),
        .illegal_o(ill[1]), .functionalUnitCode_o(unit[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Reference decode: the micro-ops one instruction expands into.
    function automatic void ref_decode(input logic [31:0] i, input bit crack,
                                       output uop_t u0, output uop_t u1, output int n);
        int              opc, xo, rt, ra, sel;
        bit              bad;
        logic signed [15:0] s;
        longint          disp;
        opc = int'(i[31:26]); rt = int'(i[25:21]); ra = int'(i[20:16]); xo = int'(i[1:0]);
        s = {i[15:2], 2'b00};
        disp = s;
        sel = -1;
        if (opc == 58 && xo != 3) sel = xo;
        if (opc == 62 && xo != 3) sel = xo + 3;
        bad = (sel < 0) || ((sel == 1 || sel == 4) && ra == 0) ||
              (sel == 1 && ra == rt) || (sel == 5 && (rt % 2) == 1);
        u0 = '0;
        u0.r1 = 5'(rt); u0.r2 = 5'(ra);
        u0.rz = (sel == 0 || sel == 2 || sel == 3 || sel == 5);
        u0.imm = 64'(disp); u0.op = 3'(sel); u0.last = 1'b1; u0.unit = 3'd2;
        u1 = u0;
        n = 1;
        if (bad) begin
            u0.ill = 1'b1; u0.op = 3'd0; u0.unit = 3'd4;
        end else if (sel == 5 && crack) begin
            u0.op = 3'd3; u0.last = 1'b0;
            u1 = u0;
            u1.r1 = 5'(rt + 1); u1.imm = 64'(disp + 8); u1.idx = 1'b1; u1.last = 1'b1;
            n = 2;
        end
    endfunction

    task automatic check_k(input int k);
        uop_t e;
        st_exp[k] = (mn[k] >= 2) || (mn[k] >= 1 && !rdy);
        chk(k == 0 ? "stall_c" : "stall_n", 64'(stall[k]), 64'(st_exp[k]));
        chk(k == 0 ? "enable_c" : "enable_n", 64'(en_o[k]), 64'(mn[k] > 0));
        if (mn[k] > 0) begin
            e = mq[k][0];
            chk("illegal", 64'(ill[k]), 64'(e.ill));
            chk("lastUop", 64'(last[k]), 64'(e.last));
            chk("unit", 64'(unit[k]), 64'(e.unit));
            chk("opSel", 64'(op[k]), 64'(e.op));
            if (!e.ill) begin
                chk("reg1", 64'(r1[k]), 64'(e.r1));
                chk("reg2", 64'(r2[k]), 64'(e.r2));
                chk("reg2ValOrZero", 64'(rz[k]), 64'(e.rz));
                chk("imm", imm[k], e.imm);
                chk("uopIdx", 64'(idx[k]), 64'(e.idx));
            end
        end else if (fresh[k]) begin
            chk("rst_reg1", 64'(r1[k]), 0);
            chk("rst_reg2", 64'(r2[k]), 0);
            chk("rst_imm", imm[k], 0);
            chk("rst_opSel", 64'(op[k]), 0);
            chk("rst_rz", 64'(rz[k]), 0);
            chk("rst_uopIdx", 64'(idx[k]), 0);
            chk("rst_lastUop", 64'(last[k]), 0);
            chk("rst_illegal", 64'(ill[k]), 0);
            chk("rst_unit", 64'(unit[k]), 0);
        end
    endtask

    // One clock: drive inputs, check current outputs, advance the model.
    task automatic cyc(input logic r, input logic e, input logic rd, input logic [31:0] i);
        uop_t a, b;
        int   n;
        @(negedge clk);
        rst = r; en_i = e; rdy = rd; ins = i;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (armed) check_k(k);
            else st_exp[k] = 1'b0;
            if (r) begin
                mn[k] = 0; fresh[k] = 1'b1;
            end else begin
                if (mn[k] > 0 && rd) begin
                    mq[k][0] = mq[k][1]; mn[k]--;
                end
                if (e && !st_exp[k]) begin
                    ref_decode(i, k == 0, a, b, n);
                    mq[k][mn[k]] = a;
                    if (n == 2) mq[k][mn[k] + 1] = b;
                    mn[k] += n; fresh[k] = 1'b0;
                end
            end
        end
        if (r) armed = 1;
    endtask

    function automatic logic [31:0] rand_ins();
        logic [5:0]  o;
        logic [4:0]  t, a;
        logic [15:0] lo;
        int          p;
        p = int'($urandom_range(7));
        o = (p < 3) ? 6'd58 : (p < 6) ? 6'd62 : 6'($urandom);
        t = 5'($urandom);
        p = int'($urandom_range(3));
        a = (p == 0) ? 5'd0 : (p == 1) ? t : 5'($urandom);
        lo = 16'($urandom);
        return {o, t, a, lo};
    endfunction

    initial begin
        mn[0] = 0; mn[1] = 0; fresh[0] = 1'b1; fresh[1] = 1'b1;
        rst = 1'b1; en_i = 1'b0; rdy = 1'b1; ins = '0;
        cyc(1, 0, 1, 0);
        cyc(1, 0, 1, 0);
        cyc(0, 0, 1, 0);
        // ld r3,8(r4) and stdu r5,-16(r1)
        cyc(0, 1, 1, 32'hE864_0008);
        cyc(0, 1, 1, 32'hF8A1_FFF1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        // stq r6,32(r7): two halves on the cracking instance
        cyc(0, 1, 1, 32'hF8C7_0022);
        cyc(0, 1, 1, 32'hE864_0008);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        // illegal: odd RS on stq, ldu with RA=0
        cyc(0, 1, 1, 32'hF8E7_0022);
        cyc(0, 1, 1, 32'hE860_0001);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        // back-pressure for three cycles
        cyc(0, 1, 1, 32'hE864_0008);
        cyc(0, 1, 0, 32'hF8A1_FFF1);
        cyc(0, 1, 0, 32'hF8A1_FFF1);
        cyc(0, 1, 0, 32'hF8A1_FFF1);
        cyc(0, 1, 1, 32'hF8A1_FFF1);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        // reset while the first STQ half is pending, with a competing enable
        cyc(0, 1, 1, 32'hF8C7_0022);
        cyc(0, 0, 0, 0);
        cyc(1, 1, 1, 32'hE864_0008);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        // randomized traffic
        for (int c = 0; c < 4000; c++)
            cyc(($urandom_range(199) == 0), ($urandom_range(3) != 0),
                ($urandom_range(3) != 0), rand_ins());
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
